// File: rtl/control_fsm.sv
// Moore main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Optional CONTROL_FSM_ILLEGAL_OP_EN adds o_IllegalOp, flagging an unsupported opcode seen in DECODE.
module control_fsm (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [6:0] i_OpCode,
    output logic       o_Branch,
    output logic       o_PCUpdate,
    output logic       o_IRWrite,
    output logic [1:0] o_ResultSrc,
    output logic       o_MemWrite,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic       o_RegWrite,
    output logic [1:0] o_ALUOp,
    output logic       o_AdrSrc,
`ifdef CONTROL_FSM_ILLEGAL_OP_EN
    output logic       o_IllegalOp,
`endif
    output logic [3:0] o_State
);

    typedef enum logic [6:0] {
        OP_LW     = 7'b0000011,
        OP_SW     = 7'b0100011,
        OP_R_TYPE = 7'b0110011,
        OP_I_TYPE = 7'b0010011,
        OP_JAL    = 7'b1101111,
        OP_BEQ    = 7'b1100011
    } OpCode_t;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEL = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } FSMState_t;

    FSMState_t state_q, state_d;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH: state_d = DECODE;
            DECODE: begin
                case (i_OpCode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R_TYPE:    state_d = EXECUTER;
                    OP_I_TYPE:    state_d = EXECUTEL;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (i_OpCode == OP_LW) begin
                    state_d = MEMREAD;
                end else if (i_OpCode == OP_SW) begin
                    state_d = MEMWRITE;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEL: state_d = ALUWB;
            JAL:      state_d = ALUWB;
            // MEMWB, MEMWRITE, ALUWB, BEQ and illegal codes all go back to FETCH
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        o_Branch    = 1'b0;
        o_PCUpdate  = 1'b0;
        o_IRWrite   = 1'b0;
        o_ResultSrc = 2'b00;
        o_MemWrite  = 1'b0;
        o_ALUSrcA   = 2'b00;
        o_ALUSrcB   = 2'b00;
        o_RegWrite  = 1'b0;
        o_ALUOp     = 2'b00;
        o_AdrSrc    = 1'b0;
        case (state_q)
            FETCH: begin
                o_IRWrite   = 1'b1;
                o_PCUpdate  = 1'b1;
                o_ALUSrcB   = 2'b10;
                o_ResultSrc = 2'b10;
            end
            DECODE: begin
                o_ALUSrcA = 2'b01;
                o_ALUSrcB = 2'b01;
            end
            MEMADR: begin
                o_ALUSrcA = 2'b10;
                o_ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                o_AdrSrc = 1'b1;
            end
            MEMWB: begin
                o_ResultSrc = 2'b01;
                o_RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                o_AdrSrc   = 1'b1;
                o_MemWrite = 1'b1;
            end
            EXECUTER: begin
                o_ALUSrcA = 2'b10;
                o_ALUOp   = 2'b10;
            end
            EXECUTEL: begin
                o_ALUSrcA = 2'b10;
                o_ALUSrcB = 2'b01;
                o_ALUOp   = 2'b10;
            end
            ALUWB: begin
                o_RegWrite = 1'b1;
            end
            JAL: begin
                o_ALUSrcA  = 2'b01;
                o_ALUSrcB  = 2'b10;
                o_PCUpdate = 1'b1;
            end
            BEQ: begin
                o_ALUSrcA = 2'b10;
                o_ALUOp   = 2'b01;
                o_Branch  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_State = state_q;

`ifdef CONTROL_FSM_ILLEGAL_OP_EN
    always_comb begin
        o_IllegalOp = 1'b0;
        if (state_q == DECODE) begin
            case (i_OpCode)
                OP_LW, OP_SW, OP_R_TYPE, OP_I_TYPE, OP_JAL, OP_BEQ: o_IllegalOp = 1'b0;
                default: o_IllegalOp = 1'b1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed + randomized bench for control_fsm: expected state/output vectors are queued per instruction
// and popped once per cycle; o_IllegalOp is also checked when CONTROL_FSM_ILLEGAL_OP_EN is defined.
module tb_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [6:0] i_OpCode;
    logic       o_Branch, o_PCUpdate, o_IRWrite, o_MemWrite, o_RegWrite, o_AdrSrc;
    logic [1:0] o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp;
    logic [3:0] o_State;
`ifdef CONTROL_FSM_ILLEGAL_OP_EN
    logic       o_IllegalOp;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [17:0] exp_q[$];

    always #5 i_Clk = ~i_Clk;

    control_fsm dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_OpCode(i_OpCode),
        .o_Branch(o_Branch), .o_PCUpdate(o_PCUpdate), .o_IRWrite(o_IRWrite),
        .o_ResultSrc(o_ResultSrc), .o_MemWrite(o_MemWrite), .o_ALUSrcA(o_ALUSrcA),
        .o_ALUSrcB(o_ALUSrcB), .o_RegWrite(o_RegWrite), .o_ALUOp(o_ALUOp),
        .o_AdrSrc(o_AdrSrc),
`ifdef CONTROL_FSM_ILLEGAL_OP_EN
        .o_IllegalOp(o_IllegalOp),
`endif
        .o_State(o_State)
    );

    // {state, Branch, PCUpdate, IRWrite, ResultSrc, MemWrite, ALUSrcA, ALUSrcB, RegWrite, ALUOp, AdrSrc}
    wire [17:0] obs = {o_State, o_Branch, o_PCUpdate, o_IRWrite, o_ResultSrc, o_MemWrite,
                       o_ALUSrcA, o_ALUSrcB, o_RegWrite, o_ALUOp, o_AdrSrc};

    function automatic logic [17:0] exp_vec(input int s);
        logic br = 0, pc = 0, ir = 0, mw = 0, rw = 0, ad = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0, op = 0;
        case (s)
            0:  begin ir = 1; pc = 1; sb = 2'b10; rs = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin ad = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin ad = 1; mw = 1; end
            6:  begin sa = 2'b10; sb = 2'b00; op = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
            8:  begin rw = 1; end
            9:  begin sa = 2'b01; sb = 2'b10; pc = 1; end
            10: begin sa = 2'b10; op = 2'b01; br = 1; end
            default: ;
        endcase
        return {4'(s), br, pc, ir, rs, mw, sa, sb, rw, op, ad};
    endfunction

    // State path for one instruction, starting at FETCH and excluding the return to FETCH.
    task automatic push_path(input logic [6:0] op);
        exp_q.push_back(exp_vec(0));
        exp_q.push_back(exp_vec(1));
        case (op)
            LW: begin exp_q.push_back(exp_vec(2)); exp_q.push_back(exp_vec(3)); exp_q.push_back(exp_vec(4)); end
            SW: begin exp_q.push_back(exp_vec(2)); exp_q.push_back(exp_vec(5)); end
            RT: begin exp_q.push_back(exp_vec(6)); exp_q.push_back(exp_vec(8)); end
            IT: begin exp_q.push_back(exp_vec(7)); exp_q.push_back(exp_vec(8)); end
            JL: begin exp_q.push_back(exp_vec(9)); exp_q.push_back(exp_vec(8)); end
            BQ: begin exp_q.push_back(exp_vec(10)); end
            default: ;
        endcase
    endtask

    function automatic logic is_legal(input logic [6:0] op);
        return op == LW || op == SW || op == RT || op == IT || op == JL || op == BQ;
    endfunction

    // Called just after a falling edge: pop one expected vector and compare.
    task automatic check_one(input string tag);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=%h required=<none>", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s observed=%h required=%h", tag, obs, e);
        end
`ifdef CONTROL_FSM_ILLEGAL_OP_EN
        n_vec++;
        assert (o_IllegalOp === (e[17:14] == 4'd1 && !is_legal(i_OpCode))) else begin
            n_err++;
            $error("FAIL %s_illegalop observed=%b required=%b", tag, o_IllegalOp,
                   (e[17:14] == 4'd1 && !is_legal(i_OpCode)));
        end
`endif
    endtask

    task automatic run_op(input logic [6:0] op, input string tag);
        int budget = 8;
        i_OpCode = op;
        push_path(op);
        while (exp_q.size() != 0 && budget > 0) begin
            check_one(tag);
            @(negedge i_Clk);
            budget--;
        end
    endtask

    initial begin
        logic [6:0] ops[7];
        ops = '{LW, SW, RT, IT, JL, BQ, BAD};
        i_Reset  = 1'b1;
        i_OpCode = 7'b0;
        @(posedge i_Clk);
        @(negedge i_Clk);
        exp_q.push_back(exp_vec(0));
        check_one("reset");
        i_Reset = 1'b0;

        run_op(LW, "lw");
        run_op(SW, "sw");
        run_op(RT, "rtype");
        run_op(IT, "itype");
        run_op(JL, "jal");
        run_op(BQ, "beq");
        run_op(BAD, "bad_op");
        run_op(7'b0000000, "zero_op");

        // Reset taken mid-lw while in MEMREAD.
        i_OpCode = LW;
        exp_q.push_back(exp_vec(0));
        exp_q.push_back(exp_vec(1));
        exp_q.push_back(exp_vec(2));
        exp_q.push_back(exp_vec(3));
        for (int i = 0; i < 4; i++) begin
            check_one("lw_pre_reset");
            if (i < 3) @(negedge i_Clk);
        end
        i_Reset = 1'b1;
        @(negedge i_Clk);
        exp_q.push_back(exp_vec(0));
        check_one("reset_in_memread");
        i_Reset = 1'b0;

        // Reset taken in DECODE.
        @(negedge i_Clk);
        i_OpCode = RT;
        exp_q.push_back(exp_vec(1));
        check_one("pre_reset_decode");
        i_Reset = 1'b1;
        @(negedge i_Clk);
        exp_q.push_back(exp_vec(0));
        check_one("reset_in_decode");
        i_Reset = 1'b0;
        @(negedge i_Clk);
        exp_q.push_back(exp_vec(1));
        check_one("decode_after_reset");
        @(negedge i_Clk);
        // The R-type proceeds from DECODE: EXECUTER, ALUWB, then FETCH.
        exp_q.push_back(exp_vec(6));
        check_one("rtype_resume");
        @(negedge i_Clk);
        exp_q.push_back(exp_vec(8));
        check_one("rtype_resume");
        @(negedge i_Clk);

        for (int k = 0; k < 30; k++) begin
            run_op(ops[$urandom_range(0, 6)], "random");
        end
        exp_q.push_back(exp_vec(0));
        check_one("final_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
